// File: rtl/climate_pkg.sv
// Shared types and constants for the climate station scheduler slice:
// scheduler state encoding, one-hot weather result codes and helpers.
package climate_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  // Operand, result and counter widths.
  localparam int OPERAND_W = 32;
  localparam int RESULT_W  = 4;
  localparam int TCOUNT_W  = 16;

  // One-hot weather result codes, bit order {snow, sunny, storm, error}.
  localparam logic [RESULT_W-1:0] RES_SNOW  = 4'b1000;
  localparam logic [RESULT_W-1:0] RES_SUNNY = 4'b0100;
  localparam logic [RESULT_W-1:0] RES_STORM = 4'b0010;
  localparam logic [RESULT_W-1:0] RES_ERROR = 4'b0001;

  // Field view of a result word; bit layout matches the constants above.
  typedef struct packed {
    logic snow;
    logic sunny;
    logic storm;
    logic error;
  } weather_result_t;

  // True when exactly one bit of v is set.
  function automatic logic is_one_hot(input logic [RESULT_W-1:0] v);
    return (v != '0) && ((v & (v - RESULT_W'(1))) == '0);
  endfunction

  // Classifier results that are not a single class collapse to error.
  function automatic weather_result_t sanitize_result(input logic [RESULT_W-1:0] v);
    return is_one_hot(v) ? weather_result_t'(v) : weather_result_t'(RES_ERROR);
  endfunction

endpackage

// File: rtl/climate_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr_i, wrapping past N-1 back to 0. Produces one-hot and binary forms.
module climate_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             enable_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    int          j;
    logic        found;
    logic [IDX_W-1:0] cand;
    // NOTE: every output gets a default before any conditional assignment;
    // a path that leaves a combinational output untouched infers a latch.
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    cand    = '0;
    if (enable_i) begin
      for (int i = 0; i < N; i++) begin
        j = int'(ptr_i) + i;
        if (j >= N) j = j - N;
        cand = IDX_W'(j);
        if (!found && req_i[cand]) begin
          found         = 1'b1;
          grant_o[cand] = 1'b1;
          idx_o         = cand;
        end
      end
    end
  end

endmodule

// File: rtl/climate_station_scheduler.sv
// Shares one climate classifier among N_STATIONS requesters. Round-robin
// grant in IDLE, one-cycle start pulse in ISSUE, bounded wait for the
// classifier's done in WAIT, and a one-cycle response to the owner in RESP.
module climate_station_scheduler
  import climate_pkg::*;
#(
  parameter int N_STATIONS     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_STATIONS-1:0]          req_valid,
  input  logic [N_STATIONS*OPERAND_W-1:0] req_temperature,
  input  logic [N_STATIONS*OPERAND_W-1:0] req_pressure,
  output logic [N_STATIONS-1:0]          req_ready,
  output logic                           cls_start,
  output logic signed [OPERAND_W-1:0]    cls_temperature,
  output logic [OPERAND_W-1:0]           cls_pressure,
  input  logic                           cls_done,
  input  logic [RESULT_W-1:0]            cls_result,
  output logic [N_STATIONS-1:0]          resp_valid,
  output logic [RESULT_W-1:0]            resp_result,
  output logic                           resp_timeout,
  output logic                           busy,
  output logic [TCOUNT_W-1:0]            timeout_count
);

  localparam int PTR_W = (N_STATIONS > 1) ? $clog2(N_STATIONS) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_STATIONS - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

  sched_state_t state_q, state_d;

  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 cls_start_q, cls_start_d;
  logic [OPERAND_W-1:0] cls_temp_q, cls_temp_d;
  logic [OPERAND_W-1:0] cls_pres_q, cls_pres_d;
  logic [N_STATIONS-1:0] resp_valid_q, resp_valid_d;
  weather_result_t      resp_result_q, resp_result_d;
  logic                 resp_timeout_q, resp_timeout_d;
  logic [TCOUNT_W-1:0]  tcount_q, tcount_d;

  logic [N_STATIONS-1:0] arb_grant;
  logic [PTR_W-1:0]      arb_idx;
  logic                  arb_any;
  logic                  wait_expired;

  // Arbitration is only live in IDLE and never while reset is asserted,
  // so req_ready reads 0 during reset.
  climate_rr_arbiter #(
    .N     (N_STATIONS),
    .IDX_W (PTR_W)
  ) u_arbiter (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .enable_i ((state_q == IDLE) && !rst),
    .grant_o  (arb_grant),
    .idx_o    (arb_idx)
  );

  assign arb_any      = |arb_grant;
  assign wait_expired = (timer_q == TMR_LIMIT);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples values from before the edge, independent of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a done in the final WAIT cycle still counts as done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_any) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cls_done || wait_expired) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; pulses default low, holds default hold.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    timer_d        = timer_q;
    cls_temp_d     = cls_temp_q;
    cls_pres_d     = cls_pres_q;
    tcount_d       = tcount_q;
    cls_start_d    = 1'b0;
    resp_valid_d   = '0;
    resp_result_d  = '0;
    resp_timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          owner_d     = arb_idx;
          rr_ptr_d    = (arb_idx == LAST_IDX) ? '0 : arb_idx + PTR_W'(1);
          cls_temp_d  = req_temperature[arb_idx*OPERAND_W +: OPERAND_W];
          cls_pres_d  = req_pressure[arb_idx*OPERAND_W +: OPERAND_W];
          cls_start_d = 1'b1;
        end
      end
      ISSUE: begin
        timer_d = '0;
      end
      WAIT: begin
        if (cls_done) begin
          resp_valid_d  = N_STATIONS'(1) << owner_q;
          resp_result_d = sanitize_result(cls_result);
        end else if (wait_expired) begin
          resp_valid_d   = N_STATIONS'(1) << owner_q;
          resp_result_d  = weather_result_t'(RES_ERROR);
          resp_timeout_d = 1'b1;
          if (tcount_q != '1) tcount_d = tcount_q + TCOUNT_W'(1);
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      timer_q        <= '0;
      cls_start_q    <= 1'b0;
      cls_temp_q     <= '0;
      cls_pres_q     <= '0;
      resp_valid_q   <= '0;
      resp_result_q  <= '0;
      resp_timeout_q <= 1'b0;
      tcount_q       <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      owner_q        <= owner_d;
      timer_q        <= timer_d;
      cls_start_q    <= cls_start_d;
      cls_temp_q     <= cls_temp_d;
      cls_pres_q     <= cls_pres_d;
      resp_valid_q   <= resp_valid_d;
      resp_result_q  <= resp_result_d;
      resp_timeout_q <= resp_timeout_d;
      tcount_q       <= tcount_d;
    end
  end

  assign req_ready       = arb_grant;
  assign cls_start       = cls_start_q;
  assign cls_temperature = cls_temp_q;
  assign cls_pressure    = cls_pres_q;
  assign resp_valid      = resp_valid_q;
  assign resp_result     = resp_result_q;
  assign resp_timeout    = resp_timeout_q;
  assign busy            = (state_q != IDLE);
  assign timeout_count   = tcount_q;

endmodule

// File: tb/tb_climate_station_scheduler.sv
// Self-checking bench for climate_station_scheduler. A transaction-level
// reference model (round-robin pick, expected latency, result rules) predicts
// every grant, operand, response and timeout count.
module tb_climate_station_scheduler;

  localparam int N = 4;
  localparam int T = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_temperature;
  logic [N*32-1:0] req_pressure;
  logic [N-1:0]    req_ready;
  logic            cls_start;
  logic [31:0]     cls_temperature;
  logic [31:0]     cls_pressure;
  logic            cls_done;
  logic [3:0]      cls_result;
  logic [N-1:0]    resp_valid;
  logic [3:0]      resp_result;
  logic            resp_timeout;
  logic            busy;
  logic [15:0]     timeout_count;

  int vectors     = 0;
  int miscompares = 0;
  int model_ptr   = 0;
  int model_tc    = 0;

  climate_station_scheduler #(
    .N_STATIONS     (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_temperature (req_temperature),
    .req_pressure    (req_pressure),
    .req_ready       (req_ready),
    .cls_start       (cls_start),
    .cls_temperature (cls_temperature),
    .cls_pressure    (cls_pressure),
    .cls_done        (cls_done),
    .cls_result      (cls_result),
    .resp_valid      (resp_valid),
    .resp_result     (resp_result),
    .resp_timeout    (resp_timeout),
    .busy            (busy),
    .timeout_count   (timeout_count)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled 3ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first requester at or after ptr, wrapping.
  function automatic int pick(input logic [N-1:0] m, input int ptr);
    logic [N-1:0] sh;
    for (int k = 0; k < N; k++) begin
      sh = m >> ((ptr + k) % N);
      if (sh[0]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Classifier output is accepted only when it names exactly one class.
  function automatic logic [3:0] expect_result(input logic [3:0] r);
    return ($countones(r) == 1) ? r : 4'b0001;
  endfunction

  task automatic randomize_slices();
    for (int s = 0; s < N; s++) begin
      req_temperature[s*32 +: 32] = $urandom;
      req_pressure[s*32 +: 32]    = $urandom;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    model_ptr = 0;
    model_tc  = 0;
  endtask

  // One request/response round trip. d is the WAIT-cycle index on which
  // done is pulsed; d >= T means the classifier never answers.
  task automatic txn(input logic [N-1:0] req_mask, input logic [N-1:0] req_after,
                     input int d, input logic [3:0] res);
    int          g;
    logic [N-1:0] exp_one;
    logic [31:0] exp_t, exp_p;
    logic [3:0]  exp_res;
    logic        exp_to;
    logic        done_seen;

    // Grant cycle.
    next_cycle();
    req_valid = req_mask;
    cls_done  = 1'b0;
    #3;
    g = pick(req_mask, model_ptr);
    exp_one = N'(1) << g;
    exp_t = req_temperature[g*32 +: 32];
    exp_p = req_pressure[g*32 +: 32];
    model_ptr = (g + 1) % N;
    vectors++;
    if (req_ready !== exp_one) begin
      miscompares++;
      $display("FAIL grant_ready: got %b want %b", req_ready, exp_one);
    end
    vectors++;
    if (busy !== 1'b0 || resp_valid !== '0) begin
      miscompares++;
      $display("FAIL grant_idle: busy=%b resp_valid=%b want 0/0", busy, resp_valid);
    end

    // Issue cycle; the owner's slice changes to prove it was captured.
    next_cycle();
    req_valid = req_after;
    req_temperature[g*32 +: 32] = $urandom;
    req_pressure[g*32 +: 32]    = $urandom;
    #3;
    vectors++;
    if (cls_start !== 1'b1 || busy !== 1'b1 || req_ready !== '0) begin
      miscompares++;
      $display("FAIL issue: start=%b busy=%b ready=%b want 1/1/0", cls_start, busy, req_ready);
    end
    vectors++;
    if (cls_temperature !== exp_t || cls_pressure !== exp_p) begin
      miscompares++;
      $display("FAIL operands: got %h/%h want %h/%h", cls_temperature, cls_pressure, exp_t, exp_p);
    end

    // Wait cycles.
    done_seen = 1'b0;
    for (int w = 0; w < T && !done_seen; w++) begin
      next_cycle();
      cls_done   = (w == d);
      cls_result = (w == d) ? res : 4'($urandom);
      #3;
      vectors++;
      if (cls_start !== 1'b0 || resp_valid !== '0 || busy !== 1'b1 ||
          cls_temperature !== exp_t || cls_pressure !== exp_p) begin
        miscompares++;
        $display("FAIL wait[%0d]: start=%b resp_valid=%b busy=%b op=%h/%h want 0/0/1 %h/%h",
                 w, cls_start, resp_valid, busy, cls_temperature, cls_pressure, exp_t, exp_p);
      end
      if (w == d) done_seen = 1'b1;
    end

    // Response cycle.
    next_cycle();
    cls_done = 1'b0;
    #3;
    if (done_seen) begin
      exp_res = expect_result(res);
      exp_to  = 1'b0;
    end else begin
      exp_res = 4'b0001;
      exp_to  = 1'b1;
      if (model_tc < 65535) model_tc++;
    end
    vectors++;
    if (resp_valid !== exp_one) begin
      miscompares++;
      $display("FAIL resp_valid: got %b want %b", resp_valid, exp_one);
    end
    vectors++;
    if (resp_result !== exp_res || resp_timeout !== exp_to) begin
      miscompares++;
      $display("FAIL resp_result: got %b/%b want %b/%b", resp_result, resp_timeout, exp_res, exp_to);
    end
    vectors++;
    if (timeout_count !== 16'(model_tc)) begin
      miscompares++;
      $display("FAIL timeout_count: got %0d want %0d", timeout_count, model_tc);
    end
  endtask

  // Idle cycles with no requests, optionally with stray done pulses.
  task automatic idle_cycles(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      req_valid  = '0;
      cls_done   = stray ? 1'($urandom) : 1'b0;
      cls_result = 4'b1000;
      #3;
      vectors++;
      if (req_ready !== '0 || busy !== 1'b0 || resp_valid !== '0 || cls_start !== 1'b0) begin
        miscompares++;
        $display("FAIL idle: ready=%b busy=%b resp_valid=%b start=%b want all 0",
                 req_ready, busy, resp_valid, cls_start);
      end
    end
    cls_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if (req_ready !== '0 || cls_start !== 1'b0 || busy !== 1'b0 || resp_valid !== '0) begin
      miscompares++;
      $display("FAIL %s_ctrl: ready=%b start=%b busy=%b resp_valid=%b want 0",
               tag, req_ready, cls_start, busy, resp_valid);
    end
    vectors++;
    if (cls_temperature !== '0 || cls_pressure !== '0) begin
      miscompares++;
      $display("FAIL %s_operands: got %h/%h want 0/0", tag, cls_temperature, cls_pressure);
    end
    vectors++;
    if (resp_result !== '0 || resp_timeout !== 1'b0 || timeout_count !== '0) begin
      miscompares++;
      $display("FAIL %s_resp: result=%b timeout=%b count=%0d want 0", tag, resp_result,
               resp_timeout, timeout_count);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    next_cycle();
    next_cycle();
    #3;
    check_all_zero("reset");
    next_cycle();
    rst       = 1'b0;
    req_valid = '0;
    model_ptr = 0;
    model_tc  = 0;
  endtask

  task automatic test_fairness();
    pulse_reset();
    randomize_slices();
    for (int i = 0; i < 5; i++) txn(4'b1111, 4'b1111, i % 3, 4'b0100);
  endtask

  task automatic test_single();
    req_temperature[2*32 +: 32] = -32'sd5;
    req_pressure[2*32 +: 32]    = 32'd975;
    txn(4'b0100, 4'b0000, 0, 4'b1000);
  endtask

  task automatic test_timeout();
    txn(4'b0010, 4'b0000, T + 5, 4'b0000);
  endtask

  task automatic test_race();
    txn(4'b1000, 4'b0000, T - 1, 4'b0010);
  endtask

  task automatic test_bad_result();
    txn(4'b0001, 4'b0000, 2, 4'b0110);
    txn(4'b0100, 4'b0000, 1, 4'b0000);
  endtask

  task automatic test_stray();
    idle_cycles(6, 1'b1);
    txn(4'b0010, 4'b0000, 0, 4'b0010);
  endtask

  task automatic test_reset_mid_wait();
    next_cycle();
    req_valid = 4'b0010;
    #3;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL midrst_grant: got %b want 0010", req_ready);
    end
    next_cycle();
    req_valid = '0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #3;
    check_all_zero("midrst");
    model_ptr = 0;
    model_tc  = 0;
    idle_cycles(T + 4, 1'b0);
    txn(4'b1000, 4'b0000, 1, 4'b0100);
  endtask

  task automatic test_withdraw();
    // Pointer is at 0 here: grant 0, then 1 while station 0 drops out.
    txn(4'b1001, 4'b1001, 0, 4'b1000);
    txn(4'b1011, 4'b1000, 1, 4'b0010);
    txn(4'b1000, 4'b0000, 0, 4'b0100);
    txn(4'b0101, 4'b0000, 0, 4'b0001);
  endtask

  task automatic test_random();
    logic [N-1:0] m;
    logic [3:0]   r;
    int           d;
    for (int i = 0; i < 40; i++) begin
      randomize_slices();
      m = N'($urandom_range(1, (1 << N) - 1));
      d = $urandom_range(0, T + 2);
      case ($urandom_range(0, 4))
        0:       r = 4'b1000;
        1:       r = 4'b0100;
        2:       r = 4'b0010;
        3:       r = 4'b0001;
        default: r = 4'($urandom);
      endcase
      txn(m, N'($urandom), d, r);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3), 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    req_valid       = '0;
    req_temperature = '0;
    req_pressure    = '0;
    cls_done        = 1'b0;
    cls_result      = '0;
    test_reset();
    test_fairness();
    test_single();
    test_timeout();
    test_race();
    test_bad_result();
    test_stray();
    test_reset_mid_wait();
    test_withdraw();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
